ama_riscv_mem_arb: RTL
======================

AMA_RISCV_MEM_ARB -- requirements
Module: ama_riscv_mem_arb

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive imem-denied cycles before imem is forced to win; legal range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  in  1  fetch request.
REQ-005 imem_req_ready  out  1  fetch granted this cycle.
REQ-006 imem_req_addr  in  14  word address.
REQ-007 imem_rsp_valid  out  1  fetch data valid.
REQ-008 imem_rsp_data  out  32  fetch data.
REQ-009 dmem_req_valid  in  1  load/store request.
REQ-010 dmem_req_ready  out  1  load/store granted this cycle.
REQ-011 dmem_req_addr  in  14  word address.
REQ-012 dmem_req_wdata  in  32  store data.
REQ-013 dmem_we  in  4  byte write enables; nonzero means store.
REQ-014 dmem_rsp_valid  out  1  load data valid or store ack.
REQ-015 dmem_rsp_data  out  32  load data.
REQ-016 mem_en  out  1  backing-memory access enable.
REQ-017 mem_we  out  4  backing-memory byte enables.
REQ-018 mem_addr  out  14  backing-memory word address.
REQ-019 mem_wdata  out  32  backing-memory write data.
REQ-020 mem_rdata  in  32  backing-memory read data, valid one cycle after mem_en.

Function
REQ-021 Single-port shared memory: at most one grant per cycle; ready is combinational from valid and starve state.
REQ-022 Priority: dmem wins when both valid, unless starve_cnt == STARVE_MAX, then imem wins.
REQ-023 starve_cnt: +1 per cycle imem_req_valid && !imem_req_ready; saturates at STARVE_MAX; cleared to 0 on imem grant or when imem_req_valid low.
REQ-024 On grant: mem_en=1, mem_addr=granted addr; mem_we=dmem_we if dmem granted, else 4'h0; mem_wdata=dmem_req_wdata (don't-care on imem grant).
REQ-025 No grant: mem_en=0, mem_we=4'h0.
REQ-026 Owner register (states OWN_NONE, OWN_IMEM, OWN_DLD, OWN_DST) loads granted type each cycle; OWN_NONE when no grant.
REQ-027 Latency exactly 1 cycle: owner OWN_IMEM -> imem_rsp_valid=1, imem_rsp_data=mem_rdata; OWN_DLD -> dmem_rsp_valid=1, dmem_rsp_data=mem_rdata; OWN_DST -> dmem_rsp_valid=1, dmem_rsp_data=32'h0.
REQ-028 Response ports have no backpressure; rsp_valid is a single-cycle pulse per grant.
REQ-029 Back-to-back grants allowed every cycle (full throughput, any port mix).
REQ-030 Requester holds valid and payload stable until ready; arbiter does not buffer ungranted requests.
REQ-031 dmem_req_valid with dmem_we=4'h0 is a load.
REQ-032 Inactive rsp_data outputs drive 32'h0.

Reset
REQ-033 During rst: all ready=0, mem_en=0, mem_we=0, both rsp_valid=0, rsp_data=0.
REQ-034 rst sets owner=OWN_NONE, starve_cnt=0; a response pending at reset assertion is dropped.
REQ-035 First grant possible in the cycle after rst deasserts.

Structure
REQ-036 Package ama_riscv_defines: arb_owner_t enum, ARB_STARVE_MAX_DEFAULT constant.
REQ-037 One sub-module: ama_riscv_sat_cnt, 4-bit saturating counter (inc, clr, max, count).

Verification
REQ-038 Imem only, addr 0x010 then 0x011 consecutive -> ready both cycles, imem_rsp_valid pulses next cycles with mem[0x010], mem[0x011].
REQ-039 Both valid, STARVE_MAX=4, dmem loads continuous -> dmem granted 4 cycles, imem granted 5th cycle, counter cleared, dmem resumes.
REQ-040 Store addr 0x020 wdata 0xDEADBEEF we 4'b0011, then load 0x020 (mem preset 0x11223344) -> dmem ack data 0, load returns 0x1122BEEF.
REQ-041 rst asserted cycle after a dmem load grant -> no dmem_rsp_valid, owner OWN_NONE, all outputs 0.
REQ-042 Alternating imem/dmem every cycle -> one grant per cycle, each rsp on correct port, never both rsp_valid high.
REQ-043 Random valid traffic -> assertion: at most one ready high, rsp count per port equals grant count per port.

Source files
------------

// File: rtl/ama_riscv_defines.sv
// Shared definitions for the instruction/data memory arbiter: owner encoding,
// starvation default and bus widths.
package ama_riscv_defines;

    localparam int ARB_STARVE_MAX_DEFAULT = 4;
    localparam int ARB_ADDR_W             = 14;
    localparam int ARB_DATA_W             = 32;
    localparam int ARB_BE_W               = 4;
    localparam int ARB_CNT_W              = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DLD  = 2'd2,
        OWN_DST  = 2'd3
    } arb_owner_t;

    // Classifies this cycle's grant into the owner whose response returns next cycle.
    function automatic arb_owner_t arb_next_owner(
        input logic                imem_gnt,
        input logic                dmem_gnt,
        input logic [ARB_BE_W-1:0] dmem_we
    );
        arb_owner_t owner;
        owner = OWN_NONE;
        if (imem_gnt) begin
            owner = OWN_IMEM;
        end else if (dmem_gnt) begin
            owner = (dmem_we != '0) ? OWN_DST : OWN_DLD;
        end
        return owner;
    endfunction

endpackage

// File: rtl/ama_riscv_sat_cnt.sv
// 4-bit up-counter that sticks at a runtime limit; clear has priority over increment.
module ama_riscv_sat_cnt
    import ama_riscv_defines::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    input  logic                 i_clr,
    input  logic [ARB_CNT_W-1:0] i_max,
    output logic [ARB_CNT_W-1:0] o_count
);

    logic [ARB_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count < i_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// Single-port memory arbiter between fetch and load/store ports: dmem has priority
// until imem has been denied STARVE_MAX cycles in a row; responses return one cycle later.
module ama_riscv_mem_arb
    import ama_riscv_defines::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT
)
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_imem_req_valid,
    output logic                  o_imem_req_ready,
    input  logic [ARB_ADDR_W-1:0] i_imem_req_addr,
    output logic                  o_imem_rsp_valid,
    output logic [ARB_DATA_W-1:0] o_imem_rsp_data,

    input  logic                  i_dmem_req_valid,
    output logic                  o_dmem_req_ready,
    input  logic [ARB_ADDR_W-1:0] i_dmem_req_addr,
    input  logic [ARB_DATA_W-1:0] i_dmem_req_wdata,
    input  logic [ARB_BE_W-1:0]   i_dmem_we,
    output logic                  o_dmem_rsp_valid,
    output logic [ARB_DATA_W-1:0] o_dmem_rsp_data,

    output logic                  o_mem_en,
    output logic [ARB_BE_W-1:0]   o_mem_we,
    output logic [ARB_ADDR_W-1:0] o_mem_addr,
    output logic [ARB_DATA_W-1:0] o_mem_wdata,
    input  logic [ARB_DATA_W-1:0] i_mem_rdata
);

    if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end

    localparam logic [ARB_CNT_W-1:0] STARVE_LIMIT = ARB_CNT_W'(STARVE_MAX);

    logic [ARB_CNT_W-1:0] w_starve_cnt;
    logic                 w_starved;
    logic                 w_imem_gnt;
    logic                 w_dmem_gnt;
    logic                 w_starve_inc;
    logic                 w_starve_clr;
    arb_owner_t           w_owner_nxt;
    arb_owner_t           r_owner;

    // Grants are purely combinational so a requester can be served in the same cycle.
    assign w_starved    = (w_starve_cnt == STARVE_LIMIT);
    assign w_imem_gnt   = !rst && i_imem_req_valid && (!i_dmem_req_valid || w_starved);
    assign w_dmem_gnt   = !rst && i_dmem_req_valid && !w_imem_gnt;
    assign w_starve_inc = i_imem_req_valid && !w_imem_gnt;
    assign w_starve_clr = !i_imem_req_valid || w_imem_gnt;

    ama_riscv_sat_cnt u_starve_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_starve_inc),
        .i_clr   (w_starve_clr),
        .i_max   (STARVE_LIMIT),
        .o_count (w_starve_cnt)
    );

    assign o_imem_req_ready = w_imem_gnt;
    assign o_dmem_req_ready = w_dmem_gnt;

    always_comb begin
        o_mem_en    = w_imem_gnt || w_dmem_gnt;
        o_mem_we    = w_dmem_gnt ? i_dmem_we : '0;
        o_mem_addr  = w_imem_gnt ? i_imem_req_addr : i_dmem_req_addr;
        o_mem_wdata = i_dmem_req_wdata;
    end

    assign w_owner_nxt = arb_next_owner(w_imem_gnt, w_dmem_gnt, i_dmem_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Reset also masks the response ports so a pending response is dropped immediately.
    always_comb begin
        o_imem_rsp_valid = 1'b0;
        o_imem_rsp_data  = '0;
        o_dmem_rsp_valid = 1'b0;
        o_dmem_rsp_data  = '0;
        if (!rst) begin
            case (r_owner)
                OWN_IMEM: begin
                    o_imem_rsp_valid = 1'b1;
                    o_imem_rsp_data  = i_mem_rdata;
                end
                OWN_DLD: begin
                    o_dmem_rsp_valid = 1'b1;
                    o_dmem_rsp_data  = i_mem_rdata;
                end
                OWN_DST: begin
                    o_dmem_rsp_valid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
